// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage stall requests, exception commit and redirect
// handshake, per-stage stall vector, flush and performance counters.
package pipe_ctrl_pkg;
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic stall_wb;
  } Stall_t;
endpackage

interface pipe_ctrl_if #(
  parameter int PERF_CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic                  stall_from_if;
  logic                  stall_from_id;
  logic                  stall_from_ex;
  logic                  stall_from_mem;
  logic                  except_occur;
  logic [31:0]           except_target;
  logic                  if_ready;
  Stall_t                stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [PERF_CNT_W-1:0] perf_stall_cycles;
  logic [PERF_CNT_W-1:0] perf_flush_cnt;

  // Pipeline side: raises requests, consumes stall/flush/redirect.
  modport master (
    output stall_from_if, stall_from_id, stall_from_ex, stall_from_mem,
    output except_occur, except_target, if_ready,
    input  stall, flush, redirect_valid, redirect_pc,
    input  perf_stall_cycles, perf_flush_cnt
  );

  // Controller side.
  modport slave (
    input  stall_from_if, stall_from_id, stall_from_ex, stall_from_mem,
    input  except_occur, except_target, if_ready,
    output stall, flush, redirect_valid, redirect_pc,
    output perf_stall_cycles, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: combinational stall priority, exception
// flush with deferred commit, and fetch redirect. Counters need PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int PERF_CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  typedef enum logic [1:0] {RUN, PEND, REDIR} state_t;

  state_t      r_state;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_captured;

  logic   w_req_mem, w_req_ex, w_req_id, w_req_if;
  logic   w_force_if;
  logic   w_take_now;
  logic   w_pend_fire;
  logic   w_flush;
  logic   w_any_stall;
  Stall_t w_stall;

  // A request from a later stage also holds every earlier stage.
  assign w_req_mem = bus.stall_from_mem;
  assign w_req_ex  = w_req_mem | bus.stall_from_ex;
  assign w_req_id  = w_req_ex  | bus.stall_from_id;
  assign w_req_if  = w_req_id  | bus.stall_from_if;

  // Outstanding redirect keeps fetch frozen; reset leaves only raw requests.
  assign w_force_if  = !rst && (r_state == REDIR);
  assign w_take_now  = !rst && bus.except_occur && !bus.stall_from_mem && (r_state != PEND);
  assign w_pend_fire = !rst && (r_state == PEND) && !bus.stall_from_mem;
  assign w_flush     = w_take_now | w_pend_fire;

  // Flushed registers must clear, so a flush cycle releases every stall.
  always_comb begin
    w_stall = '0;
    if (!w_flush) begin
      w_stall.stall_if  = w_req_if | w_force_if;
      w_stall.stall_id  = w_req_id;
      w_stall.stall_ex  = w_req_ex;
      w_stall.stall_mem = w_req_mem;
      w_stall.stall_wb  = 1'b0;
    end
  end

  assign w_any_stall = |w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_captured       <= '0;
    end else begin
      case (r_state)
        RUN, REDIR: begin
          if (bus.except_occur) begin
            if (!bus.stall_from_mem) begin
              r_redirect_pc    <= bus.except_target;
              r_redirect_valid <= 1'b1;
              r_state          <= REDIR;
            end else begin
              r_captured       <= bus.except_target;
              r_redirect_valid <= 1'b0;
              r_state          <= PEND;
            end
          end else if (r_state == REDIR && r_redirect_valid && bus.if_ready) begin
            r_redirect_valid <= 1'b0;
            r_state          <= RUN;
          end
        end
        PEND: begin
          // Later exceptions are ignored; the first captured target commits.
          if (!bus.stall_from_mem) begin
            r_redirect_pc    <= r_captured;
            r_redirect_valid <= 1'b1;
            r_state          <= REDIR;
          end
        end
        default: begin
          r_redirect_valid <= 1'b0;
          r_state          <= RUN;
        end
      endcase
    end
  end

  assign bus.stall          = w_stall;
  assign bus.flush          = w_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_flush_cnt;

  // Free-running counters wrap naturally at 2^PERF_CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_any_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush)     r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cycles = r_stall_cnt;
  assign bus.perf_flush_cnt    = r_flush_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf         = w_any_stall;
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, immediate/deferred exceptions,
// redirect handshake, reset behaviour and performance counters.
module tb_pipe_ctrl;
  localparam int CW = 4;
`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.PERF_CNT_W(CW)) bus ();
  pipe_ctrl #(.PERF_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a redirect, then compare against the oldest expected target.
  task automatic wait_redirect(input string tag);
    int n = 0;
    while (!bus.redirect_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_rv"}, {31'd0, bus.redirect_valid}, 32'd1);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    else chk({tag, "_pc"}, bus.redirect_pc, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.stall_from_if  = 1'b0;
    bus.stall_from_id  = 1'b0;
    bus.stall_from_ex  = 1'b0;
    bus.stall_from_mem = 1'b0;
    bus.except_occur   = 1'b0;
    bus.except_target  = 32'd0;
    bus.if_ready       = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_pc", bus.redirect_pc, 32'd0);
    chk("rst_perf_stall", {28'd0, bus.perf_stall_cycles}, 32'd0);
    chk("rst_perf_flush", {28'd0, bus.perf_flush_cnt}, 32'd0);
    bus.except_occur  = 1'b1;
    bus.except_target = 32'hDEADBEEF;
    bus.stall_from_ex = 1'b1;
    #1;
    chk("rst_dom_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_stall_req", bus.stall, 32'b11100);
    tick();
    chk("rst_dom_rv", {31'd0, bus.redirect_valid}, 32'd0);
    bus.except_occur  = 1'b0;
    bus.stall_from_ex = 1'b0;
    rst = 1'b0;

    // Stall priority
    bus.stall_from_mem = 1'b1; bus.stall_from_id = 1'b1; #1;
    chk("prio_mem_id", bus.stall, 32'b11110);
    bus.stall_from_mem = 1'b0; #1;
    chk("prio_id", bus.stall, 32'b11000);
    bus.stall_from_id = 1'b0; bus.stall_from_ex = 1'b1; #1;
    chk("prio_ex", bus.stall, 32'b11100);
    bus.stall_from_ex = 1'b0; bus.stall_from_if = 1'b1; #1;
    chk("prio_if", bus.stall, 32'b10000);
    bus.stall_from_if = 1'b0; #1;
    chk("prio_none", bus.stall, 32'b00000);
    tick();

    // Immediate exception with a pending ID request
    bus.stall_from_id = 1'b1;
    bus.except_occur  = 1'b1;
    bus.except_target = 32'hBFC00380;
    exp_q.push_back(32'hBFC00380);
    #1;
    chk("imm_flush", {31'd0, bus.flush}, 32'd1);
    chk("imm_stall_zero", bus.stall, 32'b00000);
    tick();
    bus.except_occur  = 1'b0;
    bus.stall_from_id = 1'b0;
    #1;
    chk("imm_no_reflush", {31'd0, bus.flush}, 32'd0);
    wait_redirect("imm");
    chk("redir_stall_if", bus.stall, 32'b10000);

    // Redirect held while IF is not ready
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_rv", {31'd0, bus.redirect_valid}, 32'd1);
      chk("hold_stall_if", {31'd0, bus.stall.stall_if}, 32'd1);
    end
    bus.if_ready = 1'b1; #1;
    chk("accept_rv_same", {31'd0, bus.redirect_valid}, 32'd1);
    tick();
    bus.if_ready = 1'b0; #1;
    chk("accept_rv_next", {31'd0, bus.redirect_valid}, 32'd0);
    chk("accept_stall", bus.stall, 32'b00000);

    // New exception while redirecting overrides the target
    bus.except_occur = 1'b1; bus.except_target = 32'hBFC00380;
    exp_q.push_back(32'hBFC00380);
    #1;
    chk("ovr_flush1", {31'd0, bus.flush}, 32'd1);
    tick();
    bus.except_occur = 1'b0;
    wait_redirect("ovr_first");
    bus.except_occur = 1'b1; bus.except_target = 32'h00000100;
    exp_q.push_back(32'h00000100);
    #1;
    chk("ovr_flush2", {31'd0, bus.flush}, 32'd1);
    tick();
    bus.except_occur = 1'b0; #1;
    chk("ovr_no_reflush", {31'd0, bus.flush}, 32'd0);
    wait_redirect("ovr_second");
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;

    // Deferred exception behind an outstanding MEM access
    bus.stall_from_mem = 1'b1;
    bus.except_occur = 1'b1; bus.except_target = 32'h80000180;
    exp_q.push_back(32'h80000180);
    #1;
    chk("def_flush_c1", {31'd0, bus.flush}, 32'd0);
    tick();
    bus.except_target = 32'h00001234; #1;
    chk("def_flush_c2", {31'd0, bus.flush}, 32'd0);
    chk("def_rv_pend", {31'd0, bus.redirect_valid}, 32'd0);
    tick();
    bus.except_occur = 1'b0; #1;
    chk("def_flush_c3", {31'd0, bus.flush}, 32'd0);
    tick();
    bus.stall_from_mem = 1'b0; #1;
    chk("def_flush_fire", {31'd0, bus.flush}, 32'd1);
    chk("def_stall_zero", bus.stall, 32'b00000);
    tick();
    chk("def_flush_once", {31'd0, bus.flush}, 32'd0);
    wait_redirect("def");
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0; #1;
    chk("def_rv_done", {31'd0, bus.redirect_valid}, 32'd0);

    // Reset while an exception is pending
    bus.stall_from_mem = 1'b1;
    bus.except_occur = 1'b1; bus.except_target = 32'h00002222;
    tick();
    bus.except_occur = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.stall_from_mem = 1'b0; #1;
    chk("rstpend_flush", {31'd0, bus.flush}, 32'd0);
    chk("rstpend_rv", {31'd0, bus.redirect_valid}, 32'd0);
    tick();
    chk("rstpend_flush_late", {31'd0, bus.flush}, 32'd0);
    chk("rstpend_rv_late", {31'd0, bus.redirect_valid}, 32'd0);

    // Performance counters (wrap at 2^CW)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.stall_from_ex = 1'b1;
    repeat (17) tick();
    bus.stall_from_ex = 1'b0; #1;
    chk("perf_stall_wrap", {28'd0, bus.perf_stall_cycles}, PERF_ON ? 32'd1 : 32'd0);
    chk("perf_flush_none", {28'd0, bus.perf_flush_cnt}, 32'd0);
    bus.except_occur = 1'b1; bus.except_target = 32'h00000040;
    tick();
    bus.except_occur = 1'b0; #1;
    chk("perf_flush_one", {28'd0, bus.perf_flush_cnt}, PERF_ON ? 32'd1 : 32'd0);
    chk("perf_stall_flushcyc", {28'd0, bus.perf_stall_cycles}, PERF_ON ? 32'd1 : 32'd0);
    bus.if_ready = 1'b1; tick(); bus.if_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
